// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKW} rx_state_t;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;

  function automatic logic [3:0] clamp_bits(input logic [3:0] n, input logic [3:0] max_bits);
    return (n < MIN_DATA_BITS || n > max_bits) ? max_bits : n;
  endfunction

  function automatic parity_t decode_parity(input logic [1:0] p);
    case (p)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, start-edge detect, per-bit tick counter and 3-sample majority vote.
module uart_rx_sampler #(
  parameter int B_TICK = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_en,
  input  logic rx_data,
  input  logic hold,
  output logic bit_valid,
  output logic bit_val,
  output logic fall,
  output logic line
);

  localparam int CW = $clog2(B_TICK);
  localparam logic [CW-1:0] T_LO   = CW'(B_TICK / 2 - 1);
  localparam logic [CW-1:0] T_MID  = CW'(B_TICK / 2);
  localparam logic [CW-1:0] T_HI   = CW'(B_TICK / 2 + 1);
  localparam logic [CW-1:0] T_LAST = CW'(B_TICK - 1);

  logic [1:0]    sync;
  logic          prev;
  logic [CW-1:0] cnt;
  logic          s_lo;
  logic          s_mid;

  assign line = sync[1];
  assign fall = prev & ~sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      prev  <= 1'b1;
      cnt   <= '0;
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
    end else begin
      sync <= {sync[0], rx_data};
      prev <= sync[1];
      // Counter is pinned at zero while idle so tick 0 lines up with the start edge.
      if (hold) begin
        cnt <= '0;
      end else if (baud_en) begin
        cnt <= (cnt == T_LAST) ? '0 : cnt + CW'(1);
        if (cnt == T_LO)  s_lo  <= line;
        if (cnt == T_MID) s_mid <= line;
      end
    end
  end

  assign bit_valid = baud_en && !hold && (cnt == T_HI);
  assign bit_val   = (s_lo & s_mid) | (s_lo & line) | (s_mid & line);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: frame FSM, data shift, parity check and commit.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int D_W    = 8,
  parameter int B_TICK = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_en,
  input  logic           rx_data,
  input  logic [3:0]     cfg_data_bits,
  input  logic [1:0]     cfg_parity,
  input  logic           cfg_stop2,
  input  logic           ff_full,
  output logic [D_W-1:0] out_data,
  output logic           ff_wr_en,
  output logic           parity_err,
  output logic           frame_err,
  output logic           overrun_err,
  output logic           break_det,
  output logic           busy,
  output rx_state_t      dbg_state
);

  localparam logic [3:0] MAX_BITS = 4'(D_W);

  rx_state_t      state, state_nx;
  logic           hold, bit_valid, bit_val, fall, line;
  logic [3:0]     n_bits, bit_idx;
  parity_t        par_mode;
  logic           stop2, stop_second;
  logic [D_W-1:0] shreg;
  logic           par_acc, par_bit, all_zero;
  logic           commit, wr_d, perr_d, ferr_d, ovr_d, brk_d;

  assign hold = (state == IDLE);

  uart_rx_sampler #(.B_TICK(B_TICK)) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .baud_en   (baud_en),
    .rx_data   (rx_data),
    .hold      (hold),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .fall      (fall),
    .line      (line)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (fall) state_nx = START;
      START:  if (bit_valid) state_nx = bit_val ? IDLE : DATA;
      DATA:   if (bit_valid && bit_idx == n_bits - 4'd1)
                state_nx = (par_mode != PAR_NONE) ? PARITY : STOP;
      PARITY: if (bit_valid) state_nx = STOP;
      STOP: begin
        if (bit_valid) begin
          if (stop_second)                state_nx = IDLE;
          else if (all_zero && !bit_val)  state_nx = BRKW;
          else if (!bit_val)              state_nx = IDLE;
          else if (!stop2)                state_nx = IDLE;
        end
      end
      BRKW:   if (line) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FIFO write: ff_wr_en is a one-cycle valid, ff_full is the inverted ready; a word is only
  // offered when the fifo can take it, otherwise it is dropped and flagged as an overrun.
  always_comb begin
    commit = (state == STOP) && bit_valid && !stop_second;
    brk_d  = commit && !bit_val && all_zero;
    ferr_d = commit && !bit_val && !all_zero;
    ovr_d  = commit && bit_val && ff_full;
    wr_d   = commit && bit_val && !ff_full;
    perr_d = wr_d && (par_mode != PAR_NONE) && (par_bit != (par_acc ^ (par_mode == PAR_ODD)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      ff_wr_en    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
      n_bits      <= MAX_BITS;
      par_mode    <= PAR_NONE;
      stop2       <= 1'b0;
      stop_second <= 1'b0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_acc     <= 1'b0;
      par_bit     <= 1'b0;
      all_zero    <= 1'b1;
    end else begin
      ff_wr_en    <= wr_d;
      parity_err  <= perr_d;
      frame_err   <= ferr_d;
      overrun_err <= ovr_d;
      break_det   <= brk_d;
      if (wr_d) out_data <= shreg;

      if (state == IDLE && fall) begin
        n_bits      <= clamp_bits(cfg_data_bits, MAX_BITS);
        par_mode    <= decode_parity(cfg_parity);
        stop2       <= cfg_stop2;
        stop_second <= 1'b0;
        bit_idx     <= '0;
        shreg       <= '0;
        par_acc     <= 1'b0;
        all_zero    <= 1'b1;
      end

      if (state == DATA && bit_valid) begin
        for (int i = 0; i < D_W; i++)
          if (bit_idx == 4'(i)) shreg[i] <= bit_val;
        par_acc  <= par_acc ^ bit_val;
        all_zero <= all_zero & ~bit_val;
        bit_idx  <= bit_idx + 4'd1;
      end

      if (state == PARITY && bit_valid) begin
        par_bit  <= bit_val;
        all_zero <= all_zero & ~bit_val;
      end

      if (commit) stop_second <= 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
